// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: rebuilds active X/Y from sampled HS/VS/BLANK_N, measures line/frame timing, locks and flags errors.
// Define VGA_MON_STATS_EN to add a saturating Err_Count of bad lines/frames seen while locked.
module vga_sync_monitor #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Pix_En,
  input  logic        HS_N,
  input  logic        VS_N,
  input  logic        BLANK_N,
  input  logic        Err_Clr,
  output logic [9:0]  Rx_X,
  output logic [9:0]  Rx_Y,
  output logic        Rx_Valid,
  output logic        Frame_Start,
  output logic        Locked,
  output logic        H_Err,
  output logic        V_Err,
  output logic [10:0] Line_Len,
  output logic [9:0]  Frame_Lines,
  output logic [15:0] Err_Count
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  localparam logic [11:0] HT = 12'(H_TOTAL);
  localparam logic [10:0] VT = 11'(V_TOTAL);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [2:0]  LF = 3'(LOCK_FRAMES);
  state_t state, state_n;
  logic [2:0] good_cnt, good_n;
  logic hs_q, vs_q, bl_q, line_seen, frame_bad;
  logic hs_fall, vs_fall, bl_fall, timeout, line_bad, frame_bad_now, set_h, set_v;
  logic [10:0] pix_cnt, pix_n, act_x, act_y;
  logic [11:0] len_m;
  logic [9:0] ln_cnt, ln_inc, rx_x_n, rx_y_n;

  always_comb begin
    hs_fall = Pix_En & hs_q & ~HS_N;
    vs_fall = Pix_En & vs_q & ~VS_N;
    bl_fall = Pix_En & bl_q & ~BLANK_N;
    pix_n = hs_fall ? '0 : (&pix_cnt ? pix_cnt : pix_cnt + 11'd1);
    timeout = Pix_En & (&pix_n);
    len_m = {1'b0, pix_cnt} + 12'd1;
    ln_inc = hs_fall && !(&ln_cnt) ? ln_cnt + 10'd1 : ln_cnt;
    act_x = {1'b0, Rx_X} + 11'd1;
    act_y = bl_fall ? {1'b0, Rx_Y} + 11'd1 : {1'b0, Rx_Y};
    rx_x_n = BLANK_N & bl_q ? (&Rx_X ? Rx_X : Rx_X + 10'd1) : '0;
    rx_y_n = vs_fall ? '0 : (bl_fall && !(&Rx_Y) ? Rx_Y + 10'd1 : Rx_Y);
    line_bad = (hs_fall & line_seen & (len_m != HT)) | (bl_fall & (act_x != HA));
    // the line closing on this strobe belongs to the frame closing on it
    frame_bad_now = frame_bad | line_bad | ({1'b0, ln_inc} != VT) | (act_y != VA);
  end

  always_comb begin
    state_n = state;
    good_n = good_cnt;
    set_h = 1'b0;
    set_v = 1'b0;
    case (state)
      SEARCH: if (vs_fall) begin
        state_n = MEASURE;
        good_n = '0;
      end
      MEASURE: if (vs_fall) begin
        good_n = frame_bad_now ? '0 : good_cnt + 3'd1;
        state_n = !frame_bad_now && good_cnt + 3'd1 == LF ? LOCKED : MEASURE;
      end
      LOCKED: begin
        set_h = line_bad;
        set_v = vs_fall & frame_bad_now;
        if (set_h | set_v) begin
          state_n = MEASURE;
          good_n = '0;
        end
      end
      default: state_n = SEARCH;
    endcase
    if (timeout) begin
      state_n = SEARCH;
      good_n = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= SEARCH;
      good_cnt <= '0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      bl_q <= 1'b0;
      line_seen <= 1'b0;
      frame_bad <= 1'b0;
      pix_cnt <= '0;
      ln_cnt <= '0;
      Rx_X <= '0;
      Rx_Y <= '0;
      Rx_Valid <= 1'b0;
      Frame_Start <= 1'b0;
      H_Err <= 1'b0;
      V_Err <= 1'b0;
      Line_Len <= '0;
      Frame_Lines <= '0;
    end else begin
      state <= state_n;
      good_cnt <= good_n;
      Frame_Start <= vs_fall;
      H_Err <= set_h | (H_Err & ~Err_Clr);
      V_Err <= set_v | (V_Err & ~Err_Clr);
      if (Pix_En) begin
        hs_q <= HS_N;
        vs_q <= VS_N;
        bl_q <= BLANK_N;
        pix_cnt <= pix_n;
        line_seen <= timeout ? 1'b0 : line_seen | hs_fall;
        frame_bad <= vs_fall ? 1'b0 : frame_bad | line_bad;
        ln_cnt <= vs_fall ? '0 : ln_inc;
        Rx_X <= rx_x_n;
        Rx_Y <= rx_y_n;
        Rx_Valid <= BLANK_N & (state_n == LOCKED);
        if (hs_fall & line_seen) Line_Len <= len_m[10:0];
        if (vs_fall) Frame_Lines <= ln_inc;
      end
    end
  end

  assign Locked = state == LOCKED;

`ifdef VGA_MON_STATS_EN
  logic [16:0] err_sum;
  assign err_sum = {1'b0, Err_Clr ? 16'd0 : Err_Count} + 17'(set_h) + 17'(set_v);
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) Err_Count <= '0;
    else Err_Count <= err_sum[16] ? '1 : err_sum[15:0];
  end
`else
  assign Err_Count = '0;
`endif
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed checks of lock, coordinate recovery and error flags on a scaled-down 20x10 raster.
module tb_vga_sync_monitor;
  logic Clk = 1'b0, Reset = 1'b1, Pix_En = 1'b0, HS_N = 1'b1, VS_N = 1'b1, BLANK_N = 1'b0, Err_Clr = 1'b0;
  logic [9:0] Rx_X, Rx_Y, Frame_Lines;
  logic Rx_Valid, Frame_Start, Locked, H_Err, V_Err;
  logic [10:0] Line_Len;
  logic [15:0] Err_Count;
  logic fs_seen = 1'b0, clr_pulse = 1'b0;
  int tests = 0, fails = 0, gx = 0, gy = 0, cur_len = 20, n_lines = 10, exp_cnt = 0;
  typedef struct { int x; int y; int rx; int ry; int vld; } vec_t;
  vec_t vt[8];
`ifdef VGA_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 Clk = ~Clk;

  vga_sync_monitor #(.H_TOTAL(20), .V_TOTAL(10), .H_ACTIVE(12), .V_ACTIVE(6), .LOCK_FRAMES(2)) dut (
    .Clk(Clk), .Reset(Reset), .Pix_En(Pix_En), .HS_N(HS_N), .VS_N(VS_N), .BLANK_N(BLANK_N),
    .Err_Clr(Err_Clr), .Rx_X(Rx_X), .Rx_Y(Rx_Y), .Rx_Valid(Rx_Valid), .Frame_Start(Frame_Start),
    .Locked(Locked), .H_Err(H_Err), .V_Err(V_Err), .Line_Len(Line_Len), .Frame_Lines(Frame_Lines),
    .Err_Count(Err_Count)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic strobe(input logic hs, input logic vs, input logic bl);
    HS_N = hs;
    VS_N = vs;
    BLANK_N = bl;
    Pix_En = 1'b1;
    Err_Clr = clr_pulse;
    @(posedge Clk);
    #1;
    Pix_En = 1'b0;
    Err_Clr = 1'b0;
    fs_seen = Frame_Start;
    @(posedge Clk);
    #1;
  endtask

  // raster: HS low x=14..16, active x<12 and y<6, VS low from line 8
  task automatic step();
    strobe(!(gx >= 14 && gx < 17), !(gy >= 8), gx < 12 && gy < 6);
    gx++;
    if (gx >= cur_len) begin
      gx = 0;
      gy = gy + 1 >= n_lines ? 0 : gy + 1;
    end
  endtask

  task automatic run_to(input int x, input int y);
    int n = 0;
    while (!(gx == x && gy == y)) begin
      step();
      n++;
      if (n > 4000) begin
        tests++;
        fails++;
        $display("FAIL run_to: at (%0d,%0d), expected to reach (%0d,%0d)", gx, gy, x, y);
        return;
      end
    end
  endtask

  task automatic next_vs();
    run_to(0, 8);
    step();
  endtask

  task automatic stretch(input logic clr);
    run_to(0, 2);
    cur_len = 21;
    run_to(0, 3);
    cur_len = 20;
    run_to(14, 3);
    clr_pulse = clr;
    step();
    clr_pulse = 1'b0;
  endtask

  task automatic err_clr();
    Err_Clr = 1'b1;
    @(posedge Clk);
    #1;
    Err_Clr = 1'b0;
  endtask

  initial begin
    vt[0] = '{0, 0, 0, 0, 1};
    vt[1] = '{5, 0, 5, 0, 1};
    vt[2] = '{11, 0, 11, 0, 1};
    vt[3] = '{12, 0, 0, 1, 0};
    vt[4] = '{0, 1, 0, 1, 1};
    vt[5] = '{11, 5, 11, 5, 1};
    vt[6] = '{12, 5, 0, 6, 0};
    vt[7] = '{0, 8, 0, 0, 0};
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_locked", Locked, 0);
    chk("rst_rx_valid", Rx_Valid, 0);
    chk("rst_line_len", Line_Len, 0);
    chk("rst_frame_lines", Frame_Lines, 0);
    chk("rst_h_err", H_Err, 0);
    chk("rst_err_count", Err_Count, 0);
    Reset = 1'b0;
    next_vs();
    chk("fs_pulse", fs_seen, 1);
    chk("fs_width", Frame_Start, 0);
    chk("locked_vs1", Locked, 0);
    next_vs();
    chk("locked_vs2", Locked, 0);
    chk("frame_lines_vs2", Frame_Lines, 10);
    next_vs();
    chk("locked_vs3", Locked, 1);
    chk("line_len_lock", Line_Len, 20);
    chk("frame_lines_lock", Frame_Lines, 10);
    chk("h_err_lock", H_Err, 0);
    chk("v_err_lock", V_Err, 0);
    for (int i = 0; i < 8; i++) begin
      run_to(vt[i].x, vt[i].y);
      step();
      chk($sformatf("rx_x[%0d]", i), Rx_X, vt[i].rx);
      chk($sformatf("rx_y[%0d]", i), Rx_Y, vt[i].ry);
      chk($sformatf("rx_valid[%0d]", i), Rx_Valid, vt[i].vld);
      chk($sformatf("locked[%0d]", i), Locked, 1);
    end
    stretch(1'b0);
    exp_cnt = 1;
    chk("h_err_stretch", H_Err, 1);
    chk("locked_stretch", Locked, 0);
    chk("line_len_stretch", Line_Len, 21);
    chk("err_count_stretch", Err_Count, STATS ? exp_cnt : 0);
    next_vs();
    chk("relock_a", Locked, 0);
    next_vs();
    chk("relock_b", Locked, 0);
    next_vs();
    chk("relock_c", Locked, 1);
    chk("h_err_sticky", H_Err, 1);
    chk("v_err_after_stretch", V_Err, 0);
    err_clr();
    exp_cnt = 0;
    chk("h_err_cleared", H_Err, 0);
    chk("err_count_cleared", Err_Count, STATS ? exp_cnt : 0);
    n_lines = 9;
    next_vs();
    n_lines = 10;
    exp_cnt = 1;
    chk("v_err_short", V_Err, 1);
    chk("frame_lines_short", Frame_Lines, 9);
    chk("locked_short", Locked, 0);
    chk("h_err_short", H_Err, 0);
    chk("err_count_short", Err_Count, STATS ? exp_cnt : 0);
    next_vs();
    chk("relock_short_a", Locked, 0);
    next_vs();
    chk("relock_short_b", Locked, 1);
    run_to(0, 0);
    repeat (2100) strobe(1'b1, 1'b1, 1'b0);
    chk("locked_timeout", Locked, 0);
    chk("rx_valid_timeout", Rx_Valid, 0);
    next_vs();
    chk("search_vs1", Locked, 0);
    next_vs();
    chk("search_vs2", Locked, 0);
    next_vs();
    chk("search_vs3", Locked, 1);
    chk("line_len_after_search", Line_Len, 20);
    stretch(1'b1);
    exp_cnt = 1;
    chk("h_err_clr_race", H_Err, 1);
    chk("v_err_clr_race", V_Err, 0);
    chk("err_count_clr_race", Err_Count, STATS ? exp_cnt : 0);
    repeat (2) begin
      next_vs();
      next_vs();
      next_vs();
      chk("relock_loop", Locked, 1);
      stretch(1'b0);
      exp_cnt++;
    end
    chk("err_count_three", Err_Count, STATS ? exp_cnt : 0);
    err_clr();
    exp_cnt = 0;
    chk("err_count_final_clr", Err_Count, STATS ? exp_cnt : 0);
    chk("h_err_final_clr", H_Err, 0);
    next_vs();
    next_vs();
    next_vs();
    chk("locked_before_reset", Locked, 1);
    run_to(5, 2);
    Reset = 1'b1;
    #1;
    chk("midreset_locked", Locked, 0);
    chk("midreset_line_len", Line_Len, 0);
    chk("midreset_frame_lines", Frame_Lines, 0);
    chk("midreset_rx_x", Rx_X, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator: samples HS/VS/BLANK_N once per pixel strobe and rebuilds the active-pixel X/Y coordinates.
- Measures line and frame length, declares lock after consecutive good frames, and raises sticky timing-error flags.
- Sits on the video output path as an on-chip checker; also feeds a capture path with Rx_X/Rx_Y/Rx_Valid.

Parameters:
H_TOTAL, 800, pixel strobes between consecutive HS falling edges
V_TOTAL, 525, HS falling edges between consecutive VS falling edges
H_ACTIVE, 640, BLANK_N-high strobes required per active line
V_ACTIVE, 480, active lines required per frame
LOCK_FRAMES, 2, consecutive good frames required to assert Locked (1..7)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high
Pix_En  in  1  pixel strobe; one Clk-wide pulse per pixel; sync inputs sampled only when high
HS_N  in  1  horizontal sync, active-low
VS_N  in  1  vertical sync, active-low
BLANK_N  in  1  high during active video
Err_Clr  in  1  synchronous clear of H_Err/V_Err
Rx_X  out  10  recovered active column
Rx_Y  out  10  recovered active row
Rx_Valid  out  1  active pixel while Locked
Frame_Start  out  1  one-Clk pulse on each detected VS falling edge
Locked  out  1  timing locked
H_Err  out  1  sticky: bad line seen while locked
V_Err  out  1  sticky: bad frame seen while locked
Line_Len  out  11  last measured line length, in strobes
Frame_Lines  out  10  last measured frame length, in lines
Err_Count  out  16  see Optional Feature

Behaviour:
- Reset is asynchronous, active-high; clock is Clk. Every output resets to 0; the FSM resets to SEARCH.
- All logic advances only on Clk edges with Pix_En=1. Edges are detected against the previously sampled value. Outputs are registered and appear 1 Clk after the sampling edge.
- Pixel counter: 11 bits, +1 per strobe, saturates at 2047. On an HS_N falling edge: Line_Len <= count+1 (the counting strobe is included) and the counter is reset. Measure is valid only once an earlier HS fall has been seen since entering SEARCH.
- Line counter: 10 bits, +1 per HS fall, saturates at 1023. On a VS_N falling edge: Frame_Lines <= count and the counter is reset. Frame_Start pulses.
- Rx_X: 0 while BLANK_N is low; +1 per strobe while high.
- Rx_Y: cleared on a VS fall; +1 on each BLANK_N falling edge.
- Active-pixel count per line and active-line count per frame are checked against H_ACTIVE and V_ACTIVE.
- Bad line: a valid Line_Len != H_TOTAL, or an active-pixel count != H_ACTIVE at the BLANK_N fall.
- Bad frame: Frame_Lines != V_TOTAL, or an active-line count != V_ACTIVE, or any bad line within the frame.
- FSM:
  - SEARCH: wait for a VS fall -> MEASURE with good_cnt=0.
  - MEASURE: on each VS fall, a good frame does good_cnt+1; when good_cnt reaches LOCK_FRAMES -> LOCKED. A bad frame sets good_cnt=0.
  - LOCKED: a bad line sets H_Err and moves to MEASURE (good_cnt=0). A bad frame sets V_Err and moves to MEASURE.
  - No HS fall within 2047 strobes (counter saturated) in any state -> SEARCH.
- Locked=1 only in LOCKED. Rx_Valid = sampled BLANK_N AND Locked.
- Err_Clr clears H_Err/V_Err. A same-cycle new error wins: the flag stays 1.
- HS and VS falling on the same strobe: line update first, then the frame update uses the incremented line count.
- Reset mid-frame: counters are discarded; the block reacquires from SEARCH.

Optional Feature:
- VGA_MON_STATS_EN defined: Err_Count is a 16-bit counter of bad lines plus bad frames detected in LOCKED. It saturates at 65535 and is cleared by Err_Clr, with the same-cycle rule (clear then +1 = 1). Resets to 0.
- Undefined: the port remains, tied to 0; no counter logic.

Test Plan:
- Generator timing (800x525, HS fall at X=656, VS fall at line 490, Pix_En every 2nd Clk) -> Locked=1 one Clk after the 3rd VS fall following reset; Line_Len=800; Frame_Lines=525; H_Err=V_Err=0.
- Locked; first active pixel after VS -> Rx_X=0, Rx_Y=0, Rx_Valid=1; last active pixel -> Rx_X=639, Rx_Y=479.
- Locked; one line stretched to 801 strobes -> H_Err=1, Locked=0, Line_Len=801; relock after 2 clean frames; H_Err stays 1 until Err_Clr.
- Locked; a frame of 524 lines -> V_Err=1, Frame_Lines=524, Locked drops.
- HS held high for 2100 strobes -> state SEARCH, Locked=0; Err_Clr asserted on the same cycle as a new error -> flag remains 1.
- VGA_MON_STATS_EN: 3 injected bad lines (with relock between each) -> Err_Count=3; Err_Clr -> 0.
